voice_scheduler: RTL

// Time-multiplexes one shared sine_function lookup across NUM_VOICES oscillator voices.
// On each sample tick it steps every voice's phase accumulator by its frequency word and

---
 rtl/synth_pkg.sv | 17 +
 rtl/voice_scheduler_regfile.sv | 65 ++++++
 rtl/voice_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and default widths for the voice scheduler slice.
package synth_pkg;

  localparam int unsigned DEF_PHASE_W    = 24;
  localparam int unsigned DEF_SINE_ARG_W = 13;
  localparam int unsigned DEF_SAMPLE_W   = 18;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_t;

  typedef logic [DEF_PHASE_W-1:0] phase_t;

endpackage

// File: rtl/voice_scheduler_regfile.sv
// Per-voice frequency, gate and phase storage with a config write port and an
// issue-stage read-modify-write port on the phase.
module voice_regfile
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned PHASE_W    = DEF_PHASE_W,
  parameter int unsigned SINE_ARG_W = DEF_SINE_ARG_W,
  localparam int unsigned VIDX_W    = $clog2(NUM_VOICES)
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_CfgWrite,
  input  logic [VIDX_W-1:0]     i_CfgVoice,
  input  logic [PHASE_W-1:0]    i_CfgFreq,
  input  logic                  i_CfgGate,
  input  logic                  i_IssueEn,
  input  logic [VIDX_W-1:0]     i_IssueVoice,
  output logic [SINE_ARG_W-1:0] o_IssueArg,
  output logic                  o_IssueGate
);

  logic [PHASE_W-1:0]    freq_q  [NUM_VOICES];
  logic [PHASE_W-1:0]    freq_d  [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;
  logic [NUM_VOICES-1:0] gate_d;
  logic [PHASE_W-1:0]    rd_phase;
  logic [PHASE_W-1:0]    rd_freq;

  // Issue-port read: pre-update phase and the config in force this cycle.
  assign rd_phase    = phase_q[i_IssueVoice];
  assign rd_freq     = freq_q[i_IssueVoice];
  assign o_IssueGate = gate_q[i_IssueVoice];
  assign o_IssueArg  = rd_phase[PHASE_W-1 -: SINE_ARG_W];

  // Phase step uses the old config; a same-cycle config write lands for the next frame.
  always_comb begin
    freq_d  = freq_q;
    gate_d  = gate_q;
    phase_d = phase_q;
    if (i_IssueEn) begin
      phase_d[i_IssueVoice] = o_IssueGate ? rd_phase + rd_freq : '0;
    end
    if (i_CfgWrite) begin
      freq_d[i_CfgVoice] = i_CfgFreq;
      gate_d[i_CfgVoice] = i_CfgGate;
    end
  end

  // Storage registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      freq_q  <= '{default: '0};
      phase_q <= '{default: '0};
      gate_q  <= '0;
    end else begin
      freq_q  <= freq_d;
      phase_q <= phase_d;
      gate_q  <= gate_d;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes one sine lookup across all voices each sample tick and mixes
// the gated results into a single sample.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 8,
  parameter int unsigned PHASE_W      = DEF_PHASE_W,
  parameter int unsigned SINE_ARG_W   = DEF_SINE_ARG_W,
  parameter int unsigned SAMPLE_W     = DEF_SAMPLE_W,
  parameter int unsigned SINE_LATENCY = 1,
  localparam int unsigned VIDX_W      = $clog2(NUM_VOICES),
  localparam int unsigned ACC_W       = SAMPLE_W + VIDX_W
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_SampleTick,
  input  logic                       i_CfgWrite,
  input  logic [VIDX_W-1:0]          i_CfgVoice,
  input  logic [PHASE_W-1:0]         i_CfgFreq,
  input  logic                       i_CfgGate,
  output logic [SINE_ARG_W-1:0]      o_SineArg,
  output logic                       o_SineArgValid,
  input  logic signed [SAMPLE_W-1:0] i_SineResult,
  output logic signed [ACC_W-1:0]    o_Sample,
  output logic                       o_SampleValid,
  output logic                       o_Busy,
  output logic                       o_Overrun
);

  // Counter steps through voices in ISSUE and through latency cycles in DRAIN.
  localparam int unsigned CNT_MAX = (NUM_VOICES > SINE_LATENCY) ? NUM_VOICES : SINE_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  sched_state_t             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  sample_q, sample_d;
  logic                     sample_valid_q, sample_valid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic [SINE_LATENCY-1:0]  tag_valid_q, tag_valid_d;
  logic [SINE_LATENCY-1:0]  tag_gate_q, tag_gate_d;
  logic                     issue_en;
  logic [SINE_ARG_W-1:0]    issue_arg;
  logic                     issue_gate;

  assign issue_en = (state_q == ISSUE);

  voice_regfile #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W),
    .SINE_ARG_W (SINE_ARG_W)
  ) u_regfile (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_CfgWrite   (i_CfgWrite),
    .i_CfgVoice   (i_CfgVoice),
    .i_CfgFreq    (i_CfgFreq),
    .i_CfgGate    (i_CfgGate),
    .i_IssueEn    (issue_en),
    .i_IssueVoice (VIDX_W'(cnt_q)),
    .o_IssueArg   (issue_arg),
    .o_IssueGate  (issue_gate)
  );

  // Sine argument is a direct decode of the state and regfile flops.
  assign o_SineArg      = issue_en ? issue_arg : '0;
  assign o_SineArgValid = issue_en;
  assign o_Sample       = sample_q;
  assign o_SampleValid  = sample_valid_q;
  assign o_Busy         = busy_q;
  assign o_Overrun      = overrun_q;

  // Next-state, alignment pipe, mix accumulation and sample publish.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    overrun_d      = i_SampleTick && (state_q != IDLE);

    tag_valid_d[0] = issue_en;
    tag_gate_d[0]  = issue_en && issue_gate;
    for (int i = 1; i < int'(SINE_LATENCY); i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_gate_d[i]  = tag_gate_q[i-1];
    end

    if (tag_valid_q[SINE_LATENCY-1] && tag_gate_q[SINE_LATENCY-1]) begin
      acc_d = acc_q + ACC_W'(i_SineResult);
    end

    case (state_q)
      IDLE: begin
        if (i_SampleTick) begin
          state_d = ISSUE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_W'(NUM_VOICES - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(SINE_LATENCY - 1)) begin
          state_d        = DONE;
          cnt_d          = '0;
          sample_d       = acc_d;
          sample_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      tag_valid_q    <= '0;
      tag_gate_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      tag_valid_q    <= tag_valid_d;
      tag_gate_q     <= tag_gate_d;
    end
  end

endmodule
